// File: rtl/huff_code_walker.sv
// Walks every Huffman leaf up to the root through a 1-cycle read port and emits one codeword
// per symbol. Define HUFF_CODE_WALKER_LSBFIRST_EN to bit-reverse code_bits within code_len.
module huff_code_walker #(
  parameter int unsigned NSYM      = 10,
  parameter int unsigned NNODE     = 19,
  parameter int unsigned MAXLEN    = 9,
  parameter int unsigned ROOT_MARK = 31
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              rd_en_o,
  output logic [4:0]        rd_addr_o,
  input  logic [18:0]       rd_data_i,
  output logic              code_valid_o,
  input  logic              code_ready_i,
  output logic [3:0]        code_sym_o,
  output logic [3:0]        code_len_o,
  output logic [MAXLEN-1:0] code_bits_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [4:0] RootMark = 5'(ROOT_MARK);
  localparam logic [4:0] NNodeW   = 5'(NNODE);
  localparam logic [3:0] MaxLenW  = 4'(MAXLEN);
  localparam logic [3:0] LastSym  = 4'(NSYM - 1);

  typedef enum logic [2:0] {StIdle, StRead, StCapt, StEmit, StDone} state_e;

  state_e            state_q;
  logic [3:0]        sym_q;
  logic [4:0]        cur_q;
  logic [3:0]        len_q;
  logic [MAXLEN-1:0] code_q;
  logic              busy_q;
  logic              rd_en_q;
  logic              code_valid_q;
  logic              done_q;
  logic              err_q;

  logic [4:0] parent;
  logic       branch;
  logic       unused_fields;

  assign parent        = rd_data_i[18:14];
  assign branch        = rd_data_i[13];
  assign unused_fields = ^rd_data_i[12:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      sym_q        <= '0;
      cur_q        <= '0;
      len_q        <= '0;
      code_q       <= '0;
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      code_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            sym_q   <= '0;
            cur_q   <= '0;
            len_q   <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            state_q <= StRead;
          end
        end
        StRead: begin
          state_q <= StCapt;
        end
        StCapt: begin
          // Root check wins over the length limit: a MAXLEN-deep leaf is legal.
          if (parent == RootMark) begin
            if (len_q == 4'd0) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              code_valid_q <= 1'b1;
              state_q      <= StEmit;
            end
          end else if (parent >= NNodeW || len_q == MaxLenW) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            code_q[len_q] <= branch;
            len_q         <= len_q + 4'd1;
            cur_q         <= parent;
            rd_en_q       <= 1'b1;
            state_q       <= StRead;
          end
        end
        StEmit: begin
          if (code_ready_i) begin
            code_valid_q <= 1'b0;
            if (sym_q == LastSym) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              sym_q   <= sym_q + 4'd1;
              cur_q   <= {1'b0, sym_q + 4'd1};
              len_q   <= '0;
              code_q  <= '0;
              rd_en_q <= 1'b1;
              state_q <= StRead;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign rd_en_o      = rd_en_q;
  assign rd_addr_o    = cur_q;
  assign code_valid_o = code_valid_q;
  assign code_sym_o   = sym_q;
  assign code_len_o   = len_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

`ifdef HUFF_CODE_WALKER_LSBFIRST_EN
  logic [MAXLEN-1:0] bits_rev;

  // Root-side bit lands in bit 0 so an LSB-first packer sends it first.
  always_comb begin
    bits_rev = '0;
    for (int i = 0; i < int'(MAXLEN); i++) begin
      if (4'(i) < len_q) begin
        bits_rev[i] = code_q[4'(len_q - 4'(i) - 4'd1)];
      end
    end
  end

  assign code_bits_o = bits_rev;
`else
  assign code_bits_o = code_q;
`endif

endmodule

// File: tb/tb_huff_code_walker.sv
// Scoreboard bench for huff_code_walker: a leaf-to-root reference model fills the expected queue,
// a negedge monitor pops and compares on every handshake and done pulse.
module tb_huff_code_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [18:0] rd_data;
  logic        code_valid;
  logic        code_ready;
  logic [3:0]  code_sym;
  logic [3:0]  code_len;
  logic [8:0]  code_bits;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;

  typedef struct {
    logic [3:0] sym;
    logic [3:0] len;
    logic [8:0] bits;
  } cw_t;

  cw_t         exp_q[$];
  bit          exp_err_q[$];
  logic [18:0] mem [32];

  logic       hold_m = 1'b0;
  logic [3:0] hold_sym;
  logic [3:0] hold_len;
  logic [8:0] hold_bits;

  always #5 clk = ~clk;

  huff_code_walker dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .busy_o      (busy),
    .rd_en_o     (rd_en),
    .rd_addr_o   (rd_addr),
    .rd_data_i   (rd_data),
    .code_valid_o(code_valid),
    .code_ready_i(code_ready),
    .code_sym_o  (code_sym),
    .code_len_o  (code_len),
    .code_bits_o (code_bits),
    .done_o      (done),
    .err_o       (err)
  );

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  initial begin
    code_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       code_ready = 1'b1;
        1:       code_ready = 1'($urandom_range(0, 1));
        default: code_ready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares on handshakes, done pulses and held outputs under backpressure.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_m) begin
        chk("hold_valid", 32'(code_valid), 32'd1);
        chk("hold_sym", 32'(code_sym), 32'(hold_sym));
        chk("hold_len", 32'(code_len), 32'(hold_len));
        chk("hold_bits", 32'(code_bits), 32'(hold_bits));
      end
      if (code_valid) chk("no_read_in_emit", 32'(rd_en), 32'd0);
      if (code_valid && code_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_code actual sym=%0d required none", code_sym);
        end else begin
          chk("code_sym", 32'(code_sym), 32'(exp_q[0].sym));
          chk("code_len", 32'(code_len), 32'(exp_q[0].len));
          chk("code_bits", 32'(code_bits), 32'(exp_q[0].bits));
          void'(exp_q.pop_front());
        end
      end
      if (done) begin
        if (exp_err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          chk("err_at_done", 32'(err), 32'(exp_err_q.pop_front()));
        end
        chk("codes_left_at_done", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
      hold_m    <= code_valid && !code_ready;
      hold_sym  <= code_sym;
      hold_len  <= code_len;
      hold_bits <= code_bits;
    end else begin
      hold_m <= 1'b0;
    end
  end

  function automatic logic [18:0] ent(int p, bit b, int self);
    return {5'(p), b, 5'(self), 8'($urandom)};
  endfunction

  task automatic build_tree(input bit balanced);
    int pool[$];
    int nxt;
    nxt = 10;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int i = 0; i < 10; i++) pool.push_back(i);
    while (pool.size() > 1) begin
      int a;
      int b;
      int ia;
      if (balanced) begin
        a = pool.pop_front();
        b = pool.pop_front();
      end else begin
        ia = $urandom_range(0, pool.size() - 1);
        a  = pool[ia];
        pool.delete(ia);
        ia = $urandom_range(0, pool.size() - 1);
        b  = pool[ia];
        pool.delete(ia);
      end
      mem[a] = ent(nxt, 1'b0, a);
      mem[b] = ent(nxt, 1'b1, b);
      pool.push_back(nxt);
      nxt++;
    end
    mem[18] = ent(31, 1'b0, 18);
  endtask

  // Reference: follow parent links from each leaf, first bit collected is the leaf's own.
  task automatic model_push(output int len0);
    len0 = 0;
    for (int s = 0; s < 10; s++) begin
      int         cur;
      int         len;
      logic [8:0] bits;
      logic [8:0] r;
      bit         bad;
      cur  = s;
      len  = 0;
      bits = '0;
      bad  = 1'b0;
      for (int it = 0; it < 16; it++) begin
        int p;
        p = int'(mem[cur][18:14]);
        if (p == 31) begin
          bad = (len == 0);
          break;
        end
        if (p >= 19 || len == 9) begin
          bad = 1'b1;
          break;
        end
        bits[len] = mem[cur][13];
        len++;
        cur = p;
      end
      if (bad) begin
        exp_err_q.push_back(1'b1);
        return;
      end
`ifdef HUFF_CODE_WALKER_LSBFIRST_EN
      r = '0;
      for (int i = 0; i < len; i++) r[i] = bits[len - 1 - i];
      bits = r;
`else
      r = bits;
`endif
      if (s == 0) len0 = len;
      exp_q.push_back('{4'(s), 4'(len), r});
    end
    exp_err_q.push_back(1'b0);
  endtask

  task automatic start_pulse();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int poke_at);
    bool_loop: begin
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        start = (c == poke_at);
        if (done) begin
          start = 1'b0;
          @(negedge clk);
          chk("done_one_cycle", 32'(done), 32'd0);
          chk("busy_after_done", 32'(busy), 32'd0);
          disable bool_loop;
        end
      end
      start = 1'b0;
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
  endtask

  task automatic run_normal(input int poke_at);
    int l0;
    model_push(l0);
    start_pulse();
    wait_done(poke_at);
  endtask

  task automatic run_latency();
    int l0;
    int got;
    model_push(l0);
    got = -1;
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    if (code_valid) got = 0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k < 60 && got < 0; k++) begin
      @(negedge clk);
      if (k == 1) chk("rd_addr_c1", 32'(rd_addr), 32'd0);
      if (k == 3) chk("rd_addr_c3", 32'(rd_addr), 32'd10);
      if (k == 5) chk("rd_addr_c5", 32'(rd_addr), 32'd18);
      if (k == 5) chk("rd_en_c5", 32'(rd_en), 32'd1);
      if (code_valid) begin
        got = k;
        chk("first_len", 32'(code_len), 32'd2);
`ifdef HUFF_CODE_WALKER_LSBFIRST_EN
        chk("first_bits", 32'(code_bits), 32'd1);
`else
        chk("first_bits", 32'(code_bits), 32'd2);
`endif
      end
    end
    chk("latency_sym0", 32'(got), 32'(2 * (l0 + 1) + 1));
    wait_done(-1);
  endtask

  task automatic run_backpressure();
    int l0;
    int seen;
    model_push(l0);
    ready_mode = 2;
    start_pulse();
    seen = 0;
    for (int k = 0; k < 100 && seen == 0; k++) begin
      @(negedge clk);
      if (code_valid) seen = 1;
    end
    chk("bp_valid_seen", 32'(seen), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_held", 32'(code_valid), 32'd1);
      chk("bp_no_read", 32'(rd_en), 32'd0);
    end
    ready_mode = 0;
    @(negedge clk);
    chk("bp_handshake", 32'(code_valid && code_ready), 32'd1);
    @(negedge clk);
    chk("bp_next_read", 32'(rd_en), 32'd1);
    chk("bp_next_addr", 32'(rd_addr), 32'd1);
    wait_done(-1);
  endtask

  task automatic run_reset_in_capt();
    int l0;
    int seen;
    model_push(l0);
    start_pulse();
    seen = 0;
    for (int k = 0; k < 50 && seen == 0; k++) begin
      @(negedge clk);
      if (rd_en) seen = 1;
    end
    chk("rst_read_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_err_q.delete();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(code_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (3) begin
      chk("rst_no_read", 32'(rd_en), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rd_en", 32'(rd_en), 32'd0);
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    chk("reset_valid", 32'(code_valid), 32'd0);
    chk("reset_sym", 32'(code_sym), 32'd0);
    chk("reset_len", 32'(code_len), 32'd0);
    chk("reset_bits", 32'(code_bits), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    build_tree(1'b1);
    mem[0]  = ent(10, 1'b0, 0);
    mem[10] = ent(18, 1'b1, 10);
    mem[18] = ent(31, 1'b0, 18);
    mem[3]  = ent(18, 1'b1, 3);
    run_latency();

    build_tree(1'b1);
    run_normal(-1);

    build_tree(1'b0);
    run_backpressure();

    build_tree(1'b1);
    mem[5] = ent(5, 1'b0, 5);
    run_normal(-1);

    build_tree(1'b1);
    mem[2] = ent(25, 1'b1, 2);
    run_normal(-1);

    // Error run then a start pulse while busy; err must clear on the next accepted start.
    build_tree(1'b0);
    ready_mode = 1;
    run_normal(12);

    build_tree(1'b1);
    mem[7] = ent(27, 1'b0, 7);
    run_normal(-1);
    run_reset_in_capt();
    build_tree(1'b1);
    run_normal(-1);

    for (int n = 0; n < 6; n++) begin
      build_tree(1'b0);
      ready_mode = 1;
      run_normal(-1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
